jam_search_param: RTL

//  Parametrised exhaustive job-assignment search: enumerates all N! worker->job permutations in

---
 rtl/jam_search_param_if.sv | 31 +++
 rtl/jam_search_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/jam_search_param_if.sv
// Handshake and cost-table bus for the job-assignment search engine.
// The master side issues Start, answers the W/J lookup with Cost and
// picks the BestW readback index. The slave side is the search engine.
interface jam_search_param_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 4
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + IW;

  logic           Start;
  logic [IW-1:0]  W;
  logic [IW-1:0]  J;
  logic [CW-1:0]  Cost;
  logic [IW-1:0]  BestW;
  logic [IW-1:0]  BestJ;
  logic [MCW-1:0] MatchCount;
  logic [SW-1:0]  MinCost;
  logic           Valid;

  modport master (
    output Start, Cost, BestW,
    input  W, J, BestJ, MatchCount, MinCost, Valid
  );

  modport slave (
    input  Start, Cost, BestW,
    output W, J, BestJ, MatchCount, MinCost, Valid
  );
endinterface

// File: rtl/jam_search_param.sv
// Exhaustive job-assignment search. Walks every worker->job permutation in
// lexicographic order (next-permutation: pivot, successor swap, suffix
// reverse) and keeps a running total so only the changed suffix is
// re-fetched from the external cost table. Reports the minimum total, how
// many permutations reach it (saturating) and the first optimal assignment.
module jam_search_param #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 4
) (
  input  logic              CLK,
  input  logic              RST,
  jam_search_param_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + IW;

  localparam logic [IW:0]   LP_N    = (IW+1)'(N);
  localparam logic [IW:0]   LP_NM1  = (IW+1)'(N - 1);
  localparam logic [IW:0]   LP_K1   = (IW+1)'(1);
  localparam logic [IW-1:0] LP_LAST = IW'(N - 1);
  localparam logic [IW-1:0] LP_ONE  = IW'(1);
  localparam logic [MCW-1:0] LP_C1  = MCW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SUM, S_PIVOT, S_SUB, S_SWAP, S_REV, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0]  r_perm [N];   // permutation currently being costed
  logic [IW-1:0]  r_best [N];   // first permutation reaching r_min
  logic [SW-1:0]  r_acc;        // running total of the current permutation
  logic [SW-1:0]  r_min;
  logic [MCW-1:0] r_cnt;
  logic [IW:0]    r_k;          // read position; reaches N at end of a sum
  logic [IW-1:0]  r_i;          // pivot scan position
  logic [IW-1:0]  r_p;          // pivot position
  logic [IW-1:0]  r_q;          // successor scan position
  logic [IW-1:0]  r_lo;         // suffix reverse, left index
  logic [IW-1:0]  r_hi;         // suffix reverse, right index

  logic [IW-1:0]  w_kidx;
  logic [IW-1:0]  w_im1;
  logic [SW-1:0]  w_cost_ext;
  logic           w_reading;
  logic           w_start;
  logic           w_sum_done;
  logic           w_pivot_hit;
  logic           w_pivot_end;
  logic           w_sub_last;
  logic           w_swap_hit;
  logic           w_rev_done;

  assign w_kidx      = r_k[IW-1:0];
  assign w_im1       = r_i - LP_ONE;
  assign w_cost_ext  = {{IW{1'b0}}, bus.Cost};
  assign w_sum_done  = (r_k == LP_N);
  assign w_reading   = ((r_state == S_SUM) && !w_sum_done) || (r_state == S_SUB);
  assign w_start     = bus.Start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_pivot_hit = (r_perm[w_im1] < r_perm[r_i]);
  assign w_pivot_end = (r_i == LP_ONE);
  assign w_sub_last  = (r_k == LP_NM1);
  assign w_swap_hit  = (r_perm[r_q] > r_perm[r_p]);
  assign w_rev_done  = !(r_lo < r_hi);

  // Cost-table lookup is only live while a suffix is being added or removed.
  assign bus.W = w_reading ? w_kidx : '0;
  assign bus.J = w_reading ? r_perm[w_kidx] : '0;

  // Result outputs; an out-of-range readback index returns job 0.
  assign bus.BestJ      = ({1'b0, bus.BestW} < LP_N) ? r_best[bus.BestW] : '0;
  assign bus.MinCost    = r_min;
  assign bus.MatchCount = r_cnt;
  assign bus.Valid      = (r_state == S_DONE);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: hold-by-default assignment first, so no branch leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_SUM;
      S_SUM:   if (w_sum_done) w_next = S_PIVOT;
      S_PIVOT: begin
        if (w_pivot_hit)      w_next = S_SUB;
        else if (w_pivot_end) w_next = S_DONE;
      end
      S_SUB:   if (w_sub_last) w_next = S_SWAP;
      S_SWAP:  if (w_swap_hit) w_next = S_REV;
      S_REV:   if (w_rev_done) w_next = S_SUM;
      S_DONE:  if (w_start) w_next = S_SUM;
      default: w_next = S_IDLE;
    endcase
  end

  // Search datapath: accumulate, compare, and step to the next permutation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: the permutation/best arrays are small register files whose reset value is
      // architecturally visible (identity), so they are reset like any other state.
      for (int i = 0; i < N; i++) begin
        r_perm[i] <= IW'(i);
        r_best[i] <= IW'(i);
      end
      r_acc <= '0;
      r_min <= '1;
      r_cnt <= '0;
      r_k   <= '0;
      r_i   <= '0;
      r_p   <= '0;
      r_q   <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.Start) begin
            for (int i = 0; i < N; i++) r_perm[i] <= IW'(i);
            r_acc <= '0;
            r_k   <= '0;
            r_min <= '1;
            r_cnt <= '0;
          end
        end
        S_SUM: begin
          if (!w_sum_done) begin
            r_acc <= r_acc + w_cost_ext;
            r_k   <= r_k + LP_K1;
          end else begin
            // Strictly better replaces best; ties only bump the count.
            if (r_acc < r_min) begin
              r_min <= r_acc;
              r_cnt <= LP_C1;
              for (int i = 0; i < N; i++) r_best[i] <= r_perm[i];
            end else if ((r_acc == r_min) && (r_cnt != '1)) begin
              r_cnt <= r_cnt + LP_C1;
            end
            r_i <= LP_LAST;
          end
        end
        S_PIVOT: begin
          if (w_pivot_hit) begin
            r_p <= w_im1;
            r_k <= {1'b0, w_im1};
          end else begin
            r_i <= w_im1;
          end
        end
        S_SUB: begin
          // Remove the suffix that is about to be rearranged.
          r_acc <= r_acc - w_cost_ext;
          r_k   <= r_k + LP_K1;
          if (w_sub_last) r_q <= LP_LAST;
        end
        S_SWAP: begin
          if (w_swap_hit) begin
            // NOTE: both non-blocking reads see the old values, so this is a true swap.
            r_perm[r_p] <= r_perm[r_q];
            r_perm[r_q] <= r_perm[r_p];
            r_lo        <= r_p + LP_ONE;
            r_hi        <= LP_LAST;
          end else begin
            r_q <= r_q - LP_ONE;
          end
        end
        S_REV: begin
          if (!w_rev_done) begin
            r_perm[r_lo] <= r_perm[r_hi];
            r_perm[r_hi] <= r_perm[r_lo];
            r_lo         <= r_lo + LP_ONE;
            r_hi         <= r_hi - LP_ONE;
          end else begin
            r_k <= {1'b0, r_p};
          end
        end
        default: ;
      endcase
    end
  end
endmodule
